dtt_crossbar_switch_rr: RTL
===========================

# dtt_crossbar_switch_rr

Parametrised N_IN x N_OUT packet crossbar. It buffers each input in a FIFO, arbitrates every output round-robin across the inputs contending for it, and provides valid/ready backpressure on both sides. It replaces the unbuffered, non-arbitrated crossbar in the datapath interconnect. Each output has a registered stage that reports the source of every beat, so downstream blocks can attribute traffic.

## Interface
- N_IN, 4: number of input ports (>= 2)
- N_OUT, 4: number of output ports (>= 2)
- DATA_WIDTH, 32: payload width
- FIFO_DEPTH, 4: entries per input FIFO (power of 2, >= 2)
- Derived: DEST_W = $clog2(N_OUT), SRC_W = $clog2(N_IN)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  [N_IN][DATA_WIDTH]  payload per input
- in_dest  in  [N_IN][DEST_W]  binary destination output index
- in_valid  in  [N_IN]  beat offered
- in_ready  out  [N_IN]  FIFO can accept
- out_data  out  [N_OUT][DATA_WIDTH]  registered payload
- out_src  out  [N_OUT][SRC_W]  input index the beat came from
- out_valid  out  [N_OUT]  beat present
- out_ready  in  [N_OUT]  sink accepts
- err_drop  out  [N_IN]  1-cycle pulse: head beat dropped for an invalid destination

## Operation
- Input accept:
  - Acceptance happens when in_valid[i] && in_ready[i].
  - in_ready[i] = !full[i]. It does not depend on a pop in the same cycle, so a full FIFO blocks even while it pops.
  - {data, dest} are written at the edge.
- FIFO:
  - Circular pointers with a wrap bit, so full and empty are both exact.
  - A beat written at edge E is visible at the head only after E (no fall-through).
- Request:
  - Input i requests output o when FIFO i is non-empty and head dest == o.
  - Each input requests at most one output per cycle.
- Output stage o can load when !out_valid[o] || out_ready[o].
- Arbitration per output:
  - Round-robin pointer last[o] holds the last granted input.
  - Search order is last[o]+1, last[o]+2, ... mod N_IN. The first requester is granted.
  - last[o] updates only on a grant (load enabled and a requester exists).
- On grant:
  - Pop the FIFO.
  - Load out_data, out_src, and set out_valid=1.
- No grant while the stage is draining (out_ready=1): out_valid goes to 0.
- While out_valid=1 && out_ready=0, out_data and out_src hold stable.
- Invalid destination (head dest >= N_OUT, possible only when N_OUT is not a power of 2):
  - The head is popped without output.
  - err_drop[i] pulses for 1 cycle.
- Head-of-line blocking is accepted behaviour: a blocked head stalls its whole input.

## Timing
- Reset (rst high at an edge):
  - All FIFOs empty; in_ready all 1 (from the cycle after the reset edge).
  - out_valid 0, out_data 0, out_src 0, err_drop 0.
  - last[o] = N_IN-1, so input 0 has first priority.
- Reset mid-operation discards all buffered and output-staged beats; nothing is replayed.
- Latency with no contention:
  - Beat accepted at edge E0 loads the output at E1.
  - out_valid is high in the cycle after E1 (2 edges).
- Throughput: 1 beat/cycle per output with out_ready held 1. Outputs operate independently and in parallel.
- Contention: k inputs targeting the same output are served in k consecutive cycles in round-robin order.
- Backpressure capacity per input-output path: FIFO_DEPTH + 1 beats (FIFO plus output stage) before in_ready drops.
- Simultaneous push and pop on a non-full FIFO: both occur; occupancy is unchanged.

## Test plan
- Reset then one-cycle burst: in0=AAAABBBB→2, in1=CCCCDDDD→2, in2=EEEEFFFF→1, in3=11112222→3, out_ready all 1.
  - 2 edges later: out1=EEEEFFFF src2, out3=11112222 src3, out2=AAAABBBB src0.
  - Next cycle: out2=CCCCDDDD src1, then out_valid[2]=0.
- Fairness: in0 and in1 stream continuously to output 0 with out_ready=1.
  - out_src[0] alternates 0,1,0,1…
  - Each input is granted exactly half over 16 cycles.
- Backpressure: out_ready[1]=0, in2 streams to output 1.
  - in_ready[2] falls after FIFO_DEPTH+1=5 accepted beats; out_data is held.
  - Releasing out_ready delivers all 5 in order, with no loss or duplication.
- Wrap-around: 3×FIFO_DEPTH sequential beats (values 0..11) from in3 to output 0, with out_ready toggling 1/0.
  - Output sequence is exactly 0..11.
- Invalid dest (N_OUT=3 build): in0 dest=3.
  - err_drop[0] pulses once; no out_valid.
  - The following in0 beat to dest 0 is delivered.
- Reset mid-operation: assert rst for 1 cycle while FIFOs hold beats and out_valid=1.
  - Next cycle: out_valid all 0, in_ready all 1.
  - Old data never appears; fresh traffic behaves as after the initial reset.

Source files
------------

// File: rtl/dtt_crossbar_switch_rr_if.sv
// rtl/dtt_crossbar_switch_rr_if.sv - input/output bundle for the round-robin packet crossbar
interface dtt_crossbar_switch_rr_if #(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int DEST_W = $clog2(N_OUT);
    localparam int SRC_W  = $clog2(N_IN);

    logic [N_IN-1:0][DATA_WIDTH-1:0]  in_data;
    logic [N_IN-1:0][DEST_W-1:0]      in_dest;
    logic [N_IN-1:0]                  in_valid;
    logic [N_IN-1:0]                  in_ready;
    logic [N_OUT-1:0][DATA_WIDTH-1:0] out_data;
    logic [N_OUT-1:0][SRC_W-1:0]      out_src;
    logic [N_OUT-1:0]                 out_valid;
    logic [N_OUT-1:0]                 out_ready;
    logic [N_IN-1:0]                  err_drop;

    modport master (
        output in_data, in_dest, in_valid, out_ready,
        input  in_ready, out_data, out_src, out_valid, err_drop
    );

    modport slave (
        input  in_data, in_dest, in_valid, out_ready,
        output in_ready, out_data, out_src, out_valid, err_drop
    );
endinterface

// File: rtl/dtt_crossbar_switch_rr.sv
// rtl/dtt_crossbar_switch_rr.sv - buffered N_IN x N_OUT crossbar with per-output round-robin arbitration
module dtt_crossbar_switch_rr #(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    dtt_crossbar_switch_rr_if.slave  bus
);
    localparam int DEST_W = $clog2(N_OUT);
    localparam int SRC_W  = $clog2(N_IN);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0]           mem_data [N_IN][FIFO_DEPTH];
    logic [DEST_W-1:0]               mem_dest [N_IN][FIFO_DEPTH];
    logic [N_IN-1:0][PTR_W:0]        wr_ptr;
    logic [N_IN-1:0][PTR_W:0]        rd_ptr;
    logic [N_IN-1:0]                 full;
    logic [N_IN-1:0]                 empty;
    logic [N_IN-1:0]                 push;
    logic [N_IN-1:0]                 pop;
    logic [N_IN-1:0]                 bad_dest;
    logic [N_IN-1:0][DATA_WIDTH-1:0] head_data;
    logic [N_IN-1:0][DEST_W-1:0]     head_dest;
    logic [N_OUT-1:0][SRC_W-1:0]     last;
    logic [N_OUT-1:0][SRC_W-1:0]     sel;
    logic [N_OUT-1:0]                load;
    logic [N_OUT-1:0]                grant;

    // The extra wrap bit on each pointer makes full and empty distinguishable.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            full[i]      = (wr_ptr[i] ^ rd_ptr[i]) == {1'b1, {PTR_W{1'b0}}};
            empty[i]     = wr_ptr[i] == rd_ptr[i];
            head_data[i] = mem_data[i][rd_ptr[i][PTR_W-1:0]];
            head_dest[i] = mem_dest[i][rd_ptr[i][PTR_W-1:0]];
            bad_dest[i]  = !empty[i] && (int'(head_dest[i]) >= N_OUT);
            push[i]      = bus.in_valid[i] && !full[i];
        end
    end

    assign bus.in_ready = ~full;

    // A head names exactly one output, so at most one output can pop a given input.
    always_comb begin
        int idx;
        idx = 0;
        pop = bad_dest;
        for (int o = 0; o < N_OUT; o++) begin
            load[o]  = !bus.out_valid[o] || bus.out_ready[o];
            grant[o] = 1'b0;
            sel[o]   = '0;
            for (int k = 1; k <= N_IN; k++) begin
                idx = int'(last[o]) + k;
                if (idx >= N_IN) begin
                    idx = idx - N_IN;
                end
                if (!grant[o] && !empty[idx] && (int'(head_dest[idx]) == o)) begin
                    grant[o] = 1'b1;
                    sel[o]   = SRC_W'(idx);
                end
            end
            if (load[o] && grant[o]) begin
                pop[sel[o]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_IN; i++) begin
            if (push[i]) begin
                mem_data[i][wr_ptr[i][PTR_W-1:0]] <= bus.in_data[i];
                mem_dest[i][wr_ptr[i][PTR_W-1:0]] <= bus.in_dest[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.out_valid <= '0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
            bus.err_drop  <= '0;
            for (int o = 0; o < N_OUT; o++) begin
                last[o] <= SRC_W'(N_IN - 1);
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
            end
            bus.err_drop <= bad_dest;
            for (int o = 0; o < N_OUT; o++) begin
                if (load[o]) begin
                    if (grant[o]) begin
                        bus.out_valid[o] <= 1'b1;
                        bus.out_data[o]  <= head_data[sel[o]];
                        bus.out_src[o]   <= sel[o];
                        last[o]          <= sel[o];
                    end else begin
                        bus.out_valid[o] <= 1'b0;
                    end
                end
            end
        end
    end
endmodule
